// File: rtl/demux_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | demux_pkg : shared types and helpers for demux_1xn_stream         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package demux_pkg;

   localparam logic SLOT_EMPTY = 1'b0;
   localparam logic SLOT_FULL  = 1'b1;

   function automatic int sel_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

   // All-ones value for a counter of width w; meaningful for w in 1..32.
   function automatic logic [31:0] sat_max(input int w);
      return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/demux_slot.sv
`default_nettype none
// +------------------------------------------------------------------+
// | demux_slot : one-entry holding register for one output channel    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module demux_slot
   import demux_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data
);

   logic              r_state;
   logic [DATA_W-1:0] r_data;

   // Load wins over drain so a same-edge drain+load keeps the slot full.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= SLOT_EMPTY;
         r_data  <= '0;
      end else if (load) begin
         r_state <= SLOT_FULL;
         r_data  <= load_data;
      end else if (out_ready) begin
         r_state <= SLOT_EMPTY;
      end
   end

   assign out_valid = (r_state == SLOT_FULL);
   assign out_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/demux_1xn_stream.sv
`default_nettype none
// +------------------------------------------------------------------+
// | demux_1xn_stream : registered 1-to-N valid/ready demultiplexer    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module demux_1xn_stream
   import demux_pkg::*;
#(
   parameter  int DATA_W  = 8,
   parameter  int NUM_OUT = 4,
   parameter  int CNT_W   = 8,
   localparam int SEL_W   = sel_width(NUM_OUT)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   input  logic [DATA_W-1:0]         in_data,
   input  logic [SEL_W-1:0]          in_sel,
   output logic                      in_ready,
   output logic [NUM_OUT-1:0]        out_valid,
   output logic [NUM_OUT*DATA_W-1:0] out_data,
   input  logic [NUM_OUT-1:0]        out_ready,
   output logic                      sel_err,
   output logic [CNT_W-1:0]          drop_cnt
);

   localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(sat_max(CNT_W));

   logic               w_sel_legal;
   logic               w_slot_ready;
   logic               w_in_ready;
   logic               w_accept;
   logic [NUM_OUT-1:0] w_load;
   logic               r_sel_err;
   logic [CNT_W-1:0]   r_drop_cnt;

   always_comb begin
      w_sel_legal  = (int'(in_sel) < NUM_OUT);
      w_slot_ready = 1'b0;
      w_load       = '0;
      for (int i = 0; i < NUM_OUT; i++) begin
         if (int'(in_sel) == i) begin
            w_slot_ready = !out_valid[i] || out_ready[i];
         end
      end
      // Illegal selects are always taken so they can be dropped and counted.
      w_in_ready = !rst && (!w_sel_legal || w_slot_ready);
      w_accept   = in_valid && w_in_ready;
      for (int i = 0; i < NUM_OUT; i++) begin
         w_load[i] = w_accept && (int'(in_sel) == i);
      end
   end

   generate
      for (genvar g = 0; g < NUM_OUT; g++) begin : g_slot
         demux_slot #(
            .DATA_W(DATA_W)
         ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .load     (w_load[g]),
            .load_data(in_data),
            .out_ready(out_ready[g]),
            .out_valid(out_valid[g]),
            .out_data (out_data[g*DATA_W +: DATA_W])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sel_err  <= 1'b0;
         r_drop_cnt <= '0;
      end else begin
         r_sel_err <= w_accept && !w_sel_legal;
         if (w_accept && !w_sel_legal && (r_drop_cnt != c_cnt_max)) begin
            r_drop_cnt <= r_drop_cnt + CNT_W'(1);
         end
      end
   end

   assign in_ready = w_in_ready;
   assign sel_err  = r_sel_err;
   assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_demux_1xn_stream.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | tb_demux_1xn_stream : scoreboard bench for demux_1xn_stream       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_demux_1xn_stream;

   localparam int DW = 8;
   localparam int NO = 5;
   localparam int CW = 8;
   localparam int SW = 3;
   localparam int CMAX = (1 << CW) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic [DW-1:0]    in_data = '0;
   logic [SW-1:0]    in_sel = '0;
   logic             in_ready;
   logic [NO-1:0]    out_valid;
   logic [NO*DW-1:0] out_data;
   logic [NO-1:0]    out_ready = '1;
   logic             sel_err;
   logic [CW-1:0]    drop_cnt;

   int checks = 0;
   int errors = 0;

   // Reference model: one capacity-1 FIFO per channel plus drop bookkeeping.
   logic [DW-1:0] q[NO][$];
   logic          acc = 1'b0;
   logic          exp_err = 1'b0;
   int            exp_drop = 0;
   int            cyc = 0;
   int            phase = 0;
   int            tp_n = 0, tp_first = 0, tp_last = 0;

   always #5 clk = ~clk;

   demux_1xn_stream #(
      .DATA_W (DW),
      .NUM_OUT(NO),
      .CNT_W  (CW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_sel   (in_sel),
      .in_ready (in_ready),
      .out_valid(out_valid),
      .out_data (out_data),
      .out_ready(out_ready),
      .sel_err  (sel_err),
      .drop_cnt (drop_cnt)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor + model step, mid-cycle while inputs are stable.
   always @(negedge clk) begin
      logic legal;
      logic rdy;
      cyc++;
      legal = int'(in_sel) < NO;
      if (rst)         rdy = 1'b0;
      else if (!legal) rdy = 1'b1;
      else             rdy = (q[in_sel].size() == 0) || out_ready[in_sel];

      if (in_valid || rst) chk("in_ready", in_ready, rdy);
      chk("sel_err", sel_err, exp_err);
      chk("drop_cnt", drop_cnt, exp_drop);

      for (int i = 0; i < NO; i++) begin
         chk($sformatf("out_valid[%0d]", i), out_valid[i], q[i].size() != 0);
         if (q[i].size() != 0) begin
            chk($sformatf("out_data[%0d]", i), out_data[i*DW +: DW], q[i][0]);
            if (out_ready[i] && !rst) begin
               void'(q[i].pop_front());
               if (phase == 7 && i == 0) begin
                  if (tp_n == 0) tp_first = cyc;
                  tp_last = cyc;
                  tp_n++;
               end
            end
         end
      end

      if (rst) begin
         for (int i = 0; i < NO; i++) q[i].delete();
         exp_err  = 1'b0;
         exp_drop = 0;
         acc      = 1'b0;
      end else begin
         acc     = in_valid && rdy;
         exp_err = acc && !legal;
         if (acc && legal) q[in_sel].push_back(in_data);
         if (exp_err && exp_drop < CMAX) exp_drop++;
      end
   end

   // Present a beat and hold it until the model says it was taken.
   task automatic send(input int s, input int d);
      int n = 0;
      in_valid = 1'b1;
      in_sel   = SW'(s);
      in_data  = DW'(d);
      forever begin
         @(posedge clk);
         if (acc) break;
         n++;
         if (n > 64) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=stalled required=accept sel=%0d", s);
            break;
         end
      end
      #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_drop_cnt", drop_cnt, 0);
      chk("rst_in_ready", in_ready, 0);
      rst = 1'b0;

      phase = 2;
      for (int s = 0; s < 4; s++) begin
         send(s, 8'h11 * (s + 1));
         chk("route_valid", out_valid, 64'(1 << s));
         chk("route_data", out_data[s*DW +: DW], 64'(8'h11 * (s + 1)));
      end
      idle(2);

      phase = 3;
      out_ready = 5'b11011;
      send(2, 8'hA5);
      in_data = 8'h5A;
      repeat (3) @(posedge clk);
      #1;
      chk("bp_stall_ready", in_ready, 0);
      chk("bp_hold_data", out_data[2*DW +: DW], 8'hA5);
      out_ready = '1;
      send(2, 8'h5A);
      chk("bp_reload_valid", out_valid[2], 1);
      chk("bp_reload_data", out_data[2*DW +: DW], 8'h5A);
      idle(2);

      phase = 4;
      out_ready = 5'b11101;
      send(1, 8'h33);
      send(3, 8'h7E);
      in_valid = 1'b0;
      chk("indep_valid", out_valid, 5'b01010);
      chk("indep_ch1_data", out_data[1*DW +: DW], 8'h33);
      out_ready = '1;
      idle(2);

      phase = 5;
      send(5, 8'hFF);
      in_valid = 1'b0;
      chk("err_pulse", sel_err, 1);
      chk("err_cnt", drop_cnt, 1);
      chk("err_no_valid", out_valid, 0);
      idle(1);
      chk("err_pulse_end", sel_err, 0);
      for (int k = 0; k < 300; k++) send(5 + int'($urandom_range(0, 2)), int'($urandom));
      in_valid = 1'b0;
      chk("drop_saturate", drop_cnt, CMAX);
      idle(2);

      phase = 6;
      out_ready = '0;
      send(0, 8'hC0);
      send(3, 8'hC3);
      idle(1);
      chk("pre_rst_valid", out_valid, 5'b01001);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_drop", drop_cnt, 0);
      chk("mid_rst_err", sel_err, 0);
      out_ready = '1;
      send(1, 8'h99);
      in_valid = 1'b0;
      chk("post_rst_route", out_valid, 5'b00010);
      idle(2);

      phase = 7;
      for (int d = 0; d < 16; d++) send(0, d);
      idle(3);
      phase = 8;
      chk("tput_count", tp_n, 16);
      chk("tput_span", tp_last - tp_first, 15);

      for (int c = 0; c < 3000; c++) begin
         if (!(in_valid && !acc)) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_sel   = SW'($urandom_range(0, 7));
            in_data  = DW'($urandom);
         end
         out_ready = NO'($urandom);
         rst       = ($urandom_range(0, 149) == 0);
         @(posedge clk);
         #1;
      end
      rst       = 1'b0;
      out_ready = '1;
      idle(4);
      chk("final_empty", out_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
